// File: rtl/daq_frame_packer.sv
// daq_frame_packer: buffers decimated samples in a FIFO and emits header + FRAME_LEN sample-word frames.
// Define DAQ_FRAME_CHECKSUM_EN to append a modulo-2^32 sum trailer word to every frame.
module daq_frame_packer #(
    parameter int         DW         = 24,
    parameter int         FRAME_LEN  = 64,
    parameter int         FIFO_DEPTH = 128,
    parameter logic [7:0] SYNC       = 8'hA5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [DW-1:0]                 in_data,
    output logic [31:0]                   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   drop_cnt,
    input  logic                          drop_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

`ifdef DAQ_FRAME_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, HDR, DATA, CSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`endif

    state_t                state_q, state_d;
    logic [DW-1:0]         mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [15:0]           drop_q, drop_d, cnt_q, cnt_d;
    logic [7:0]            seq_q, seq_d;
    logic                  wr, rd, hs, last_data;
    logic signed [DW-1:0]  head_raw;
    logic [31:0]           head;
`ifdef DAQ_FRAME_CHECKSUM_EN
    logic [31:0]           sum_q, sum_d;
`endif

    always_comb begin
        head_raw  = mem_q[rd_ptr_q];
        head      = 32'(head_raw);
        last_data = cnt_q == 16'(FRAME_LEN - 1);
        out_valid = state_q != IDLE;
        out_data  = state_q == HDR ? {SYNC, seq_q, 16'(FRAME_LEN)} : state_q == DATA ? head : 32'h0;
`ifdef DAQ_FRAME_CHECKSUM_EN
        out_last  = state_q == CSUM;
        out_data  = state_q == CSUM ? sum_q : out_data;
`else
        out_last  = state_q == DATA && last_data;
`endif
        hs        = out_valid && out_ready;
        // Fullness is judged at cycle start; a same-cycle pop never frees room for this write.
        wr        = in_valid && level_q != LW'(FIFO_DEPTH);
        rd        = hs && state_q == DATA;
        level_d   = level_q + LW'(wr) - LW'(rd);
        wr_ptr_d  = wr_ptr_q + AW'(wr);
        rd_ptr_d  = rd_ptr_q + AW'(rd);
        drop_d    = drop_clr ? 16'h0 : (in_valid && !wr && drop_q != 16'hFFFF) ? drop_q + 16'h1 : drop_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        seq_d     = seq_q;
        case (state_q)
            // Looking at next-cycle occupancy lets the header appear right after the completing write.
            IDLE: state_d = level_d >= LW'(FRAME_LEN) ? HDR : IDLE;
            HDR: if (hs) begin
                state_d = DATA;
                cnt_d   = 16'h0;
            end
            DATA: if (hs) begin
                cnt_d = cnt_q + 16'h1;
`ifdef DAQ_FRAME_CHECKSUM_EN
                state_d = last_data ? CSUM : DATA;
`else
                state_d = last_data ? IDLE : DATA;
                seq_d   = last_data ? seq_q + 8'h1 : seq_q;
`endif
            end
`ifdef DAQ_FRAME_CHECKSUM_EN
            CSUM: if (hs) begin
                state_d = IDLE;
                seq_d   = seq_q + 8'h1;
            end
`endif
            default: state_d = IDLE;
        endcase
`ifdef DAQ_FRAME_CHECKSUM_EN
        sum_d = state_q == HDR ? 32'h0 : rd ? sum_q + head : sum_q;
`endif
    end

    always_ff @(posedge clk)
        if (wr) mem_q[wr_ptr_q] <= in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
            cnt_q    <= '0;
            seq_q    <= '0;
`ifdef DAQ_FRAME_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            seq_q    <= seq_d;
`ifdef DAQ_FRAME_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    assign fifo_level = level_q;
    assign drop_cnt   = drop_q;
endmodule

// File: tb/tb_daq_frame_packer.sv
// tb_daq_frame_packer: directed checks of framing, sequencing, overflow, reset and stall behaviour.
module tb_daq_frame_packer;
    localparam int FL = 4;
    localparam int FD = 8;
`ifdef DAQ_FRAME_CHECKSUM_EN
    localparam int FW = FL + 2;
`else
    localparam int FW = FL + 1;
`endif

    logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, drop_clr = 0;
    logic [23:0] in_data = 0;
    logic [31:0] out_data;
    logic        out_valid, out_last;
    logic [3:0]  fifo_level;
    logic [15:0] drop_cnt;

    daq_frame_packer #(.DW(24), .FRAME_LEN(FL), .FIFO_DEPTH(FD), .SYNC(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .fifo_level(fifo_level), .drop_cnt(drop_cnt), .drop_clr(drop_clr)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0, gf_cycles;
    logic        hs_s, hs_v, hs_l;
    logic [31:0] hs_d;
    logic [31:0] fw [0:5];
    logic        fl [0:5];
    logic [7:0]  exp_seq = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic c);
        in_valid = v; in_data = d[23:0]; out_ready = r; drop_clr = c;
        hs_v = out_valid; hs_s = out_valid && r; hs_d = out_data; hs_l = out_last;
        @(posedge clk); #1;
    endtask

    task automatic get_frame();
        int n = 0;
        gf_cycles = 0;
        while (n < FW && gf_cycles < 50) begin
            step(0, 0, 1, 0);
            gf_cycles++;
            if (hs_s) begin
                fw[n] = hs_d; fl[n] = hs_l; n++;
            end
        end
        chk("frame_words", n, FW);
    endtask

    task automatic chk_frame(input logic [31:0] s0, s1, s2, s3);
        chk("hdr", fw[0], {8'hA5, exp_seq, 16'h0004});
        chk("d0", fw[1], s0); chk("d1", fw[2], s1); chk("d2", fw[3], s2); chk("d3", fw[4], s3);
`ifdef DAQ_FRAME_CHECKSUM_EN
        chk("trailer", fw[5], s0 + s1 + s2 + s3);
`endif
        for (int i = 0; i < FW; i++) chk("last_flag", 32'(fl[i]), 32'(i == FW - 1));
        exp_seq++;
    endtask

    task automatic frame(input logic [31:0] s0, s1, s2, s3);
        step(1, s0, 0, 0); step(1, s1, 0, 0); step(1, s2, 0, 0); step(1, s3, 0, 0);
        get_frame();
        chk_frame(s0, s1, s2, s3);
    endtask

    logic [31:0] q [$];
    logic [31:0] rsum, exp_w, prev_d, smp;
    logic        prev_stall, prev_l, v, r;
    int          pos;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 0); chk("rst_last", 32'(out_last), 0);
        chk("rst_data", out_data, 0); chk("rst_level", 32'(fifo_level), 0); chk("rst_drop", 32'(drop_cnt), 0);
        rst_n = 1;
        step(0, 0, 1, 0);

        step(1, 32'h1, 1, 0); step(1, 32'h2, 1, 0); step(1, 32'hFFFFFFFF, 1, 0);
        chk("no_valid_3", 32'(out_valid), 0);
        step(1, 32'hFFFFFFFE, 1, 0);
        chk("valid_rise", 32'(out_valid), 1); chk("level4", 32'(fifo_level), 4);
        get_frame();
        chk("t1_hdr", fw[0], 32'hA5000004); chk("t1_d0", fw[1], 32'h00000001);
        chk("t1_d1", fw[2], 32'h00000002); chk("t1_d2", fw[3], 32'hFFFFFFFF); chk("t1_d3", fw[4], 32'hFFFFFFFE);
        chk("t1_last", 32'(fl[FW-1]), 1); chk("t1_notlast", 32'(fl[FW-2]), 0);
`ifdef DAQ_FRAME_CHECKSUM_EN
        chk("t1_trailer", fw[5], 32'h00000000);
`endif
        exp_seq = 1;

        frame(32'h10, 32'h11, 32'h12, 32'h13);
        chk("hdr_seq1", fw[0], 32'hA5010004);
        frame(32'hFF800000, 32'h007FFFFF, 32'h0, 32'hFFFFFF00);
        chk("hdr_seq2", fw[0], 32'hA5020004);
        while (exp_seq != 8'hFF) frame(32'h5, 32'h6, 32'h7, 32'h8);
        frame(32'h21, 32'h22, 32'h23, 32'h24);
        chk("hdr_ff", fw[0], 32'hA5FF0004);
        frame(32'h31, 32'h32, 32'h33, 32'h34);
        chk("hdr_wrap", fw[0], 32'hA5000004);

        for (int i = 0; i < 20; i++) begin
            step(i < 10, 32'(100 + i), 0, 0);
            if (i >= 3) chk("stall_hdr", out_data, 32'hA5010004);
        end
        chk("stall_valid", 32'(out_valid), 1);
        chk("ovf_level", 32'(fifo_level), 8); chk("ovf_drop", 32'(drop_cnt), 2);
        get_frame(); chk_frame(100, 101, 102, 103);
        chk("tput_first", 32'(gf_cycles), FW);
        get_frame(); chk_frame(104, 105, 106, 107);
        chk("tput_b2b", 32'(gf_cycles <= FW + 1), 1);
        chk("drained", 32'(fifo_level), 0);

        step(1, 32'h41, 0, 0); step(1, 32'h42, 0, 0); step(1, 32'h43, 0, 0); step(1, 32'h44, 0, 0);
        step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0);
        rst_n = 0; #1;
        chk("mid_rst_valid", 32'(out_valid), 0); chk("mid_rst_level", 32'(fifo_level), 0);
        chk("mid_rst_drop", 32'(drop_cnt), 0);
        @(posedge clk); #1; rst_n = 1;
        exp_seq = 0;
        frame(32'h51, 32'h52, 32'h53, 32'h54);
        chk("post_rst_hdr", fw[0], 32'hA5000004);

        for (int i = 0; i < 9; i++) step(1, 32'(200 + i), 0, 0);
        chk("drop1", 32'(drop_cnt), 1);
        step(1, 32'd209, 0, 1);
        chk("clr_prio", 32'(drop_cnt), 0);
        step(1, 32'd210, 0, 0);
        chk("drop_again", 32'(drop_cnt), 1);
        get_frame(); chk_frame(200, 201, 202, 203);
        get_frame(); chk_frame(204, 205, 206, 207);
        step(0, 0, 1, 1);
        chk("clr_plain", 32'(drop_cnt), 0);

`ifdef DAQ_FRAME_CHECKSUM_EN
        frame(32'h007FFFFF, 32'h007FFFFF, 32'h007FFFFF, 32'h007FFFFF);
        chk("csum_max", fw[5], 32'h01FFFFFC);
`endif

        pos = 0; rsum = 0; prev_stall = 0; prev_d = 0; prev_l = 0;
        for (int c = 0; c < 700 && (c < 192 || q.size() > 0 || pos != 0); c++) begin
            v   = c < 192 && c % 4 == 0;
            smp = 32'(c * 1000 - 90000);
            r   = c >= 192 || $urandom_range(0, 3) != 0;
            if (prev_stall) begin
                chk("stall_data", out_data, prev_d); chk("stall_last", 32'(out_last), 32'(prev_l));
                chk("stall_keep", 32'(out_valid), 1);
            end
            step(v, smp, r, 0);
            if (v) q.push_back(smp);
            prev_stall = hs_v && !r; prev_d = hs_d; prev_l = hs_l;
            if (hs_s) begin
                if (pos == 0) begin
                    chk("rnd_hdr", hs_d, {8'hA5, exp_seq, 16'h0004});
                    rsum = 0;
                end else if (pos <= FL) begin
                    exp_w = q.size() > 0 ? q.pop_front() : 32'hDEADBEEF;
                    chk("rnd_data", hs_d, exp_w);
                    rsum = rsum + exp_w;
                end else chk("rnd_trailer", hs_d, rsum);
                chk("rnd_last", 32'(hs_l), 32'(pos == FW - 1));
                if (pos == FW - 1) exp_seq++;
                pos = (pos + 1) % FW;
            end
        end
        chk("rnd_all_out", 32'(q.size()), 0); chk("rnd_frame_end", 32'(pos), 0);
        chk("rnd_no_drop", 32'(drop_cnt), 0); chk("rnd_empty", 32'(fifo_level), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/daq_frame_packer.md
Name: daq_frame_packer

Overview:
Downstream of down_sample. Takes the decimated signed 24-bit samples (valid pulse, no backpressure) and buffers them in an internal FIFO. Emits fixed-length frames on a 32-bit valid/ready stream toward the DAQ uplink: one header word, then FRAME_LEN sign-extended sample words. Counts samples dropped on FIFO overflow.

Parameters:
DW, 24, input sample width (signed), 2..32
FRAME_LEN, 64, sample words per frame, 1..FIFO_DEPTH
FIFO_DEPTH, 128, sample FIFO depth, power of two, >= FRAME_LEN
SYNC, 8'hA5, header sync byte

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  one-cycle sample strobe from down_sample
in_data  in  DW  signed sample, sampled when in_valid=1
out_data  out  32  frame word
out_valid  out  1  out_data valid
out_ready  in  1  sink accepts word when out_valid&out_ready
out_last  out  1  marks final word of frame
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
drop_cnt  out  16  dropped-sample count, saturating
drop_clr  in  1  synchronous clear of drop_cnt

Behaviour:
- Reset (async, rst_n=0): FIFO empty, fifo_level=0, FSM=IDLE, seq=0, drop_cnt=0, out_valid=0, out_last=0, out_data=0. Reset mid-frame abandons the frame with no trailer; the next frame starts at seq=0.
- Write: in_valid=1 and FIFO not full at cycle start -> sample written. If full -> sample discarded; drop_cnt+1, saturating at 16'hFFFF. A read in the same cycle does not free space for that write.
- drop_clr=1 -> drop_cnt=0 next cycle. drop_clr takes priority over a simultaneous increment.
- Simultaneous FIFO write and read -> fifo_level unchanged.
- Sample word: in_data sign-extended to 32 bits; e.g. 24'h800000 -> 32'hFF800000.
- Header word: {SYNC, seq[7:0], FRAME_LEN[15:0]}.
- FSM states: IDLE, HDR, DATA (CSUM when the optional feature is enabled).
- IDLE -> HDR when fifo_level >= FRAME_LEN. The whole frame is buffered, so a frame never stalls on an empty FIFO.
- out_valid rises the cycle after the write that brings fifo_level to FRAME_LEN.
- HDR: header presented. On handshake -> DATA with word counter=0.
- DATA: present FIFO head (first-word-fall-through or prefetch register; no bubble cycles while out_ready=1).
  - Each handshake pops one sample.
  - After the FRAME_LEN-th handshake -> IDLE (or CSUM).
  - out_last=1 on the final word of the frame.
- Stream rules:
  - While out_valid=1 and out_ready=0, out_data, out_last and out_valid stay stable.
  - out_valid never drops without a handshake.
  - Throughput: one word per cycle with out_ready held high.
  - Back-to-back frames: if fifo_level >= FRAME_LEN at frame end, HDR follows with at most one idle cycle.
- seq increments on acceptance of the frame's last word; wraps 255 -> 0.
- FIFO continues accepting input during output backpressure. Overflow is the only loss mechanism.

Optional Feature:
Macro DAQ_FRAME_CHECKSUM_EN.
- Defined: a trailer word follows the data words, equal to the 32-bit modulo-2^32 sum of the FRAME_LEN sign-extended sample words of that frame.
  - out_last moves to the trailer word.
  - Frame length becomes FRAME_LEN+2 words.
  - The accumulator clears at HDR.
- Undefined: no CSUM state, no accumulator logic; the frame is FRAME_LEN+1 words.

Test Plan:
- FRAME_LEN=4, FIFO_DEPTH=8, out_ready=1; write 1,2,-1,-2 -> output A5000004, 00000001, 00000002, FFFFFFFF, FFFFFFFE; out_last on the last word; out_valid rises the cycle after the 4th write.
- Three consecutive frames of 4 samples -> headers A5000004, A5010004, A5020004. Force seq from 255 -> header A5FF0004, then A5000004.
- out_ready=0 for 20 cycles while 10 samples arrive -> 8 stored, drop_cnt=2, out_data held at the header. Then out_ready=1 -> two full frames with the first 8 samples in order. drop_clr pulse -> drop_cnt=0.
- Assert rst_n=0 after 2 data words of a frame -> out_valid=0, fifo_level=0, drop_cnt=0 immediately. Next frame header A5000004.
- Random out_ready toggling with continuous input below FIFO capacity -> every sample appears exactly once, in order, with no data change while stalled.
- DAQ_FRAME_CHECKSUM_EN defined, samples 1,2,-1,-2 -> trailer word 00000000 with out_last; samples 7FFFFF ×4 -> trailer 01FFFFFC.
